// File: rtl/branch_flag_stage.sv
// rtl/branch_flag_stage.sv - EX->MEM flag producer with two-entry skid buffer
module branch_flag_stage #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    input  logic [2:0]       in_branch,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       out_branch,
    output logic [WIDTH-1:0] out_result,
    output logic             out_sf,
    output logic             out_zf,
    output logic             out_of,
    output logic             out_cf
);

    localparam int EW = WIDTH + 7;

    logic [WIDTH-1:0] b_op;
    logic [WIDTH:0]   sum;
    logic             f_sf, f_zf, f_of, f_cf;
    logic [EW-1:0]    new_entry;

    assign b_op = in_sub ? ~in_b : in_b;
    assign sum  = {1'b0, in_a} + {1'b0, b_op} + {{WIDTH{1'b0}}, in_sub};
    assign f_sf = sum[WIDTH-1];
    assign f_zf = (sum[WIDTH-1:0] == '0);
    assign f_cf = sum[WIDTH];
    assign f_of = (in_a[WIDTH-1] == b_op[WIDTH-1]) && (sum[WIDTH-1] != in_a[WIDTH-1]);
    assign new_entry = {in_branch, sum[WIDTH-1:0], f_sf, f_zf, f_of, f_cf};

    logic [EW-1:0] main_q, main_d, skid_q, skid_d;
    logic          main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
    logic          in_ready_q;
    logic          accept, pop;

    assign accept = in_valid && in_ready_q && !flush;
    assign pop    = main_vld_q && out_ready;

    always_comb begin
        main_d     = main_q;
        skid_d     = skid_q;
        main_vld_d = main_vld_q;
        skid_vld_d = skid_vld_q;
        if (flush) begin
            // Data is left stale; only the valid bits are cleared.
            main_vld_d = 1'b0;
            skid_vld_d = 1'b0;
        end else if (skid_vld_q) begin
            if (pop) begin
                main_d     = skid_q;
                skid_vld_d = 1'b0;
            end
        end else if (main_vld_q) begin
            if (accept && pop) begin
                main_d = new_entry;
            end else if (accept) begin
                skid_d     = new_entry;
                skid_vld_d = 1'b1;
            end else if (pop) begin
                main_vld_d = 1'b0;
            end
        end else if (accept) begin
            main_d     = new_entry;
            main_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q     <= '0;
            skid_q     <= '0;
            main_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            main_q     <= main_d;
            skid_q     <= skid_d;
            main_vld_q <= main_vld_d;
            skid_vld_q <= skid_vld_d;
            in_ready_q <= !skid_vld_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = main_vld_q;
    assign out_branch = main_q[EW-1 -: 3];
    assign out_result = main_q[WIDTH+3:4];
    assign out_sf     = main_q[3];
    assign out_zf     = main_q[2];
    assign out_of     = main_q[1];
    assign out_cf     = main_q[0];

endmodule
